// File: rtl/udp_tx_scheduler_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM states, UDP header
// constants and the saturating total-length helper.
package udp_tx_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_LOAD,
      ST_XFER,
      ST_GAP
   } state_t;

   localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
   localparam logic [15:0] UDP_CKSUM_NONE = 16'h0000;

   typedef struct packed {
      logic [15:0] tot_len;
      logic        err;
   } tot_len_t;

   // Payload length plus header, clamped to 16'hFFFF when it overflows 16 bits.
   function automatic tot_len_t calc_tot_len(input logic [15:0] len);
      logic [16:0] sum;
      tot_len_t    res;
      sum         = {1'b0, len} + {1'b0, UDP_HDR_LEN};
      res.err     = sum[16];
      res.tot_len = sum[16] ? 16'hFFFF : sum[15:0];
      return res;
   endfunction

endpackage

// File: rtl/udp_tx_scheduler_arbiter.sv
// Round-robin request picker: first active request at or after i_ptr,
// wrapping modulo NUM_CH.
module udp_rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [CH_W-1:0]   i_ptr,
   output logic [NUM_CH-1:0] o_grant,
   output logic [CH_W-1:0]   o_idx,
   output logic              o_valid
);

   int w_ch;

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_ch    = 0;
      // Walk from the farthest offset down so the nearest request wins last.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         w_ch = (int'(i_ptr) + k) % NUM_CH;
         if (i_req[w_ch]) begin
            o_grant       = '0;
            o_grant[w_ch] = 1'b1;
            o_idx         = CH_W'(w_ch);
            o_valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Packet-granular round-robin scheduler feeding one UDP header-insert stage
// from NUM_CH byte-wide AXI-Stream sources.
module udp_tx_scheduler
   import udp_tx_scheduler_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic                 s_axis_aclk,
   input  logic                 s_axis_areset,
   input  logic [8*NUM_CH-1:0]  ch_tdata,
   input  logic [NUM_CH-1:0]    ch_tvalid,
   input  logic [NUM_CH-1:0]    ch_tlast,
   output logic [NUM_CH-1:0]    ch_tready,
   input  logic [16*NUM_CH-1:0] ch_len,
   input  logic [16*NUM_CH-1:0] ch_src_port,
   input  logic [16*NUM_CH-1:0] ch_dst_port,
   output logic [15:0]          udp_src_port,
   output logic [15:0]          udp_dst_port,
   output logic [15:0]          udp_tot_len,
   output logic [15:0]          udp_checksum,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   input  logic                 m_axis_tready,
   output logic [NUM_CH-1:0]    grant,
   output logic                 len_err
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   state_t             r_state;
   logic [CH_W-1:0]    r_ptr;
   logic [CH_W-1:0]    r_idx;
   logic [NUM_CH-1:0]  r_grant;
   logic [15:0]        r_src_port;
   logic [15:0]        r_dst_port;
   logic [15:0]        r_tot_len;
   logic               r_len_err;
   logic               r_sop;
   logic [GAP_W-1:0]   r_gap_cnt;

   logic [NUM_CH-1:0]  w_arb_grant;
   logic [CH_W-1:0]    w_arb_idx;
   logic               w_arb_valid;
   logic [CH_W-1:0]    w_next_ptr;
   logic               w_xfer;
   logic               w_hs;
   tot_len_t           w_tot;

   udp_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .i_req   (ch_tvalid),
      .i_ptr   (r_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   assign w_tot      = calc_tot_len(ch_len[16*int'(w_arb_idx) +: 16]);
   assign w_next_ptr = (r_idx == CH_W'(NUM_CH - 1)) ? '0 : r_idx + 1'b1;

   // Payload path is a pure mux on the registered owner: no added latency.
   assign w_xfer        = (r_state == ST_XFER);
   assign m_axis_tvalid = w_xfer & ch_tvalid[r_idx];
   assign m_axis_tdata  = w_xfer ? ch_tdata[8*int'(r_idx) +: 8] : 8'h00;
   assign m_axis_tlast  = m_axis_tvalid & ch_tlast[r_idx];
   assign m_axis_tuser  = m_axis_tvalid & r_sop;
   assign w_hs          = m_axis_tvalid & m_axis_tready;

   always_comb begin
      ch_tready        = '0;
      ch_tready[r_idx] = w_xfer & m_axis_tready;
   end

   assign grant        = r_grant;
   assign udp_src_port = r_src_port;
   assign udp_dst_port = r_dst_port;
   assign udp_tot_len  = r_tot_len;
   assign udp_checksum = UDP_CKSUM_NONE;
   assign len_err      = r_len_err;

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_idx      <= '0;
         r_grant    <= '0;
         r_src_port <= '0;
         r_dst_port <= '0;
         r_tot_len  <= '0;
         r_len_err  <= 1'b0;
         r_sop      <= 1'b0;
         r_gap_cnt  <= '0;
      end else begin
         r_len_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|ch_tvalid) r_state <= ST_ARB;
            end
            ST_ARB: begin
               if (w_arb_valid) begin
                  r_grant    <= w_arb_grant;
                  r_idx      <= w_arb_idx;
                  r_src_port <= ch_src_port[16*int'(w_arb_idx) +: 16];
                  r_dst_port <= ch_dst_port[16*int'(w_arb_idx) +: 16];
                  r_tot_len  <= w_tot.tot_len;
                  r_len_err  <= w_tot.err;
                  r_sop      <= 1'b1;
                  r_state    <= ST_LOAD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               r_state <= ST_XFER;
            end
            ST_XFER: begin
               if (w_hs) begin
                  r_sop <= 1'b0;
                  if (m_axis_tlast) begin
                     r_ptr     <= w_next_ptr;
                     r_grant   <= '0;
                     r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                     r_state   <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               // Requests arriving here wait for ARB; the count lets the
               // insert stage settle back to idle before the next tuser.
               if (r_gap_cnt == '0) begin
                  r_state <= (|ch_tvalid) ? ST_ARB : ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Self-checking bench: queued packets per source, a packet-level scoreboard
// with a round-robin ownership model, and directed phases for the key cases.
module tb_udp_tx_scheduler;

   localparam int NUM_CH     = 2;
   localparam int GAP_CYCLES = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [8*NUM_CH-1:0]  ch_tdata;
   logic [NUM_CH-1:0]    ch_tvalid;
   logic [NUM_CH-1:0]    ch_tlast;
   logic [NUM_CH-1:0]    ch_tready;
   logic [16*NUM_CH-1:0] ch_len;
   logic [16*NUM_CH-1:0] ch_src_port;
   logic [16*NUM_CH-1:0] ch_dst_port;
   logic [15:0]          udp_src_port;
   logic [15:0]          udp_dst_port;
   logic [15:0]          udp_tot_len;
   logic [15:0]          udp_checksum;
   logic [7:0]           m_axis_tdata;
   logic                 m_axis_tvalid;
   logic                 m_axis_tlast;
   logic                 m_axis_tuser;
   logic                 m_axis_tready;
   logic [NUM_CH-1:0]    grant;
   logic                 len_err;

   always #5 clk = ~clk;

   udp_tx_scheduler #(
      .NUM_CH     (NUM_CH),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .s_axis_aclk   (clk),
      .s_axis_areset (rst),
      .ch_tdata      (ch_tdata),
      .ch_tvalid     (ch_tvalid),
      .ch_tlast      (ch_tlast),
      .ch_tready     (ch_tready),
      .ch_len        (ch_len),
      .ch_src_port   (ch_src_port),
      .ch_dst_port   (ch_dst_port),
      .udp_src_port  (udp_src_port),
      .udp_dst_port  (udp_dst_port),
      .udp_tot_len   (udp_tot_len),
      .udp_checksum  (udp_checksum),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tready (m_axis_tready),
      .grant         (grant),
      .len_err       (len_err)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Source side: what each generator still has to offer.
   int unsigned src_nb    [NUM_CH][$];
   logic [15:0] src_len   [NUM_CH][$];
   logic [15:0] src_sp    [NUM_CH][$];
   logic [15:0] src_dp    [NUM_CH][$];
   logic [7:0]  src_bytes [NUM_CH][$];
   int          src_pos   [NUM_CH];

   // Scoreboard side: what the insert stage must still receive.
   int unsigned sb_nb    [NUM_CH][$];
   logic [15:0] sb_len   [NUM_CH][$];
   logic [15:0] sb_sp    [NUM_CH][$];
   logic [15:0] sb_dp    [NUM_CH][$];
   logic [7:0]  sb_bytes [NUM_CH][$];

   int          ptr_m;
   int          cur_ch;
   bit          in_pkt;
   int          sb_pos;
   int          gap_left;
   int          cyc;
   int          t_last;
   bit          pend_after;
   int          lenerr_seen;
   int          lenerr_exp;
   logic [15:0] exp_tot;
   logic [NUM_CH-1:0] prev_grant;
   logic [NUM_CH-1:0] order_log[$];

   int rdy_mode;
   bit bubbles_on;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int c = 0; c < NUM_CH; c++) begin
         src_nb[c].delete();  src_len[c].delete(); src_sp[c].delete();
         src_dp[c].delete();  src_bytes[c].delete();
         sb_nb[c].delete();   sb_len[c].delete();  sb_sp[c].delete();
         sb_dp[c].delete();   sb_bytes[c].delete();
         src_pos[c] = 0;
      end
      ptr_m       = 0;
      cur_ch      = 0;
      in_pkt      = 1'b0;
      sb_pos      = 0;
      gap_left    = 0;
      t_last      = 0;
      pend_after  = 1'b0;
      lenerr_seen = 0;
      lenerr_exp  = 0;
      prev_grant  = '0;
   endtask

   task automatic add_pkt(input int c, input int nb, input logic [15:0] len,
                          input logic [15:0] sp, input logic [15:0] dp);
      logic [7:0] b;
      src_nb[c].push_back(nb);  sb_nb[c].push_back(nb);
      src_len[c].push_back(len); sb_len[c].push_back(len);
      src_sp[c].push_back(sp);  sb_sp[c].push_back(sp);
      src_dp[c].push_back(dp);  sb_dp[c].push_back(dp);
      for (int i = 0; i < nb; i++) begin
         b = 8'($urandom);
         src_bytes[c].push_back(b);
         sb_bytes[c].push_back(b);
      end
   endtask

   function automatic int rr_pick();
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = (ptr_m + k) % NUM_CH;
         if (sb_nb[c].size() > 0) return c;
      end
      return -1;
   endfunction

   function automatic int remaining();
      int r;
      r = gap_left + (in_pkt ? 1 : 0);
      for (int c = 0; c < NUM_CH; c++) r += sb_bytes[c].size();
      return r;
   endfunction

   task automatic drive();
      bit bubble;
      for (int c = 0; c < NUM_CH; c++) begin
         if (src_nb[c].size() > 0) begin
            bubble = bubbles_on && (src_pos[c] > 0) && ($urandom_range(0, 2) == 0);
            ch_tvalid[c]          = !bubble;
            ch_tdata[8*c +: 8]    = src_bytes[c][0];
            ch_tlast[c]           = (src_pos[c] == int'(src_nb[c][0]) - 1);
            ch_len[16*c +: 16]      = src_len[c][0];
            ch_src_port[16*c +: 16] = src_sp[c][0];
            ch_dst_port[16*c +: 16] = src_dp[c][0];
         end else begin
            ch_tvalid[c]            = 1'b0;
            ch_tdata[8*c +: 8]      = 8'h00;
            ch_tlast[c]             = 1'b0;
            ch_len[16*c +: 16]      = 16'h0000;
            ch_src_port[16*c +: 16] = 16'h0000;
            ch_dst_port[16*c +: 16] = 16'h0000;
         end
      end
      case (rdy_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = ~m_axis_tready;
         default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic sample();
      logic [NUM_CH-1:0] eg;
      int c;
      int tot;
      cyc++;
      lenerr_seen += int'(len_err);
      check("tready_owner", 64'(ch_tready & ~grant), 64'(0));
      if (gap_left > 0) begin
         check("gap_tvalid", 64'(m_axis_tvalid), 64'(0));
         check("gap_tready", 64'(ch_tready), 64'(0));
         gap_left--;
      end

      // Source-side consumption.
      for (int s = 0; s < NUM_CH; s++) begin
         if (ch_tvalid[s] && ch_tready[s] && src_nb[s].size() > 0) begin
            void'(src_bytes[s].pop_front());
            src_pos[s]++;
            if (src_pos[s] == int'(src_nb[s][0])) begin
               void'(src_nb[s].pop_front());
               void'(src_len[s].pop_front());
               void'(src_sp[s].pop_front());
               void'(src_dp[s].pop_front());
               src_pos[s] = 0;
            end
         end
      end

      // A fresh owner appears: header fields must already be valid.
      if (grant != '0 && prev_grant == '0) begin
         c = rr_pick();
         if (c < 0 || in_pkt) begin
            check("spurious_grant", 64'(grant), 64'(0));
         end else begin
            eg    = '0;
            eg[c] = 1'b1;
            order_log.push_back(grant);
            tot     = int'(sb_len[c][0]) + 8;
            exp_tot = (tot > 65535) ? 16'hFFFF : 16'(tot);
            check("grant", 64'(grant), 64'(eg));
            check("hdr_src_port", 64'(udp_src_port), 64'(sb_sp[c][0]));
            check("hdr_dst_port", 64'(udp_dst_port), 64'(sb_dp[c][0]));
            check("hdr_tot_len", 64'(udp_tot_len), 64'(exp_tot));
            check("hdr_checksum", 64'(udp_checksum), 64'(0));
            check("len_err_at_load", 64'(len_err), 64'(tot > 65535));
            if (rdy_mode == 0 && pend_after)
               check("b2b_spacing", 64'(cyc - t_last), 64'(GAP_CYCLES + 2));
            pend_after = 1'b0;
            if (tot > 65535) lenerr_exp++;
            cur_ch = c;
            in_pkt = 1'b1;
            sb_pos = 0;
         end
      end

      // Output-side beats.
      if (m_axis_tvalid && m_axis_tready) begin
         if (!in_pkt) begin
            check("beat_outside_pkt", 64'(m_axis_tvalid), 64'(0));
         end else begin
            check("tuser", 64'(m_axis_tuser), 64'(sb_pos == 0));
            check("tdata", 64'(m_axis_tdata), 64'(sb_bytes[cur_ch][0]));
            check("tlast", 64'(m_axis_tlast), 64'(sb_pos == int'(sb_nb[cur_ch][0]) - 1));
            check("hdr_hold", 64'(udp_tot_len), 64'(exp_tot));
            void'(sb_bytes[cur_ch].pop_front());
            sb_pos++;
            if (sb_pos == int'(sb_nb[cur_ch][0])) begin
               void'(sb_nb[cur_ch].pop_front());
               void'(sb_len[cur_ch].pop_front());
               void'(sb_sp[cur_ch].pop_front());
               void'(sb_dp[cur_ch].pop_front());
               in_pkt     = 1'b0;
               sb_pos     = 0;
               ptr_m      = (cur_ch + 1) % NUM_CH;
               gap_left   = GAP_CYCLES;
               t_last     = cyc;
               pend_after = (rr_pick() >= 0);
               check("len_err_count", 64'(lenerr_seen), 64'(lenerr_exp));
            end
         end
      end
      prev_grant = grant;
   endtask

   task automatic tick();
      @(negedge clk);
      drive();
      #3;
      sample();
   endtask

   task automatic run_until_done(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (remaining() > 0 && n < max_cyc) begin
         tick();
         n++;
      end
      check(tag, 64'(remaining()), 64'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_hdr"}, {udp_src_port, udp_dst_port, udp_tot_len, udp_checksum}, 64'(0));
      check({tag, "_strm"},
            64'({ch_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, grant, len_err}),
            64'(0));
   endtask

   initial begin
      rst           = 1'b1;
      ch_tdata      = '0;
      ch_tvalid     = '0;
      ch_tlast      = '0;
      ch_len        = '0;
      ch_src_port   = '0;
      ch_dst_port   = '0;
      m_axis_tready = 1'b0;
      rdy_mode      = 0;
      bubbles_on    = 1'b0;
      cyc           = 0;
      reset_model();

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) tick();
      check_all_zero("idle");

      // Reset in the middle of a ch0 packet, then a clean restart.
      add_pkt(0, 10, 16'd10, 16'd100, 16'd200);
      for (int i = 0; i < 200 && src_pos[0] < 5; i++) tick();
      check("t1_reach_byte5", 64'(src_pos[0]), 64'(5));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("mid_pkt_reset");
      reset_model();
      ch_tvalid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      add_pkt(0, 10, 16'd10, 16'd100, 16'd200);
      run_until_done("t1_restart_drain", 200);

      // Single ch0 packet with known header fields.
      add_pkt(0, 10, 16'd10, 16'd1234, 16'd5678);
      run_until_done("t2_drain", 200);

      // 1-byte packet on ch1 competing with ch0.
      add_pkt(0, 4, 16'd4, 16'h0011, 16'h0022);
      run_until_done("t6_setup_drain", 200);
      order_log.delete();
      add_pkt(1, 1, 16'd1, 16'h0aaa, 16'h0bbb);
      add_pkt(0, 3, 16'd3, 16'h0ccc, 16'h0ddd);
      run_until_done("t6_drain", 200);
      check("t6_order_n", 64'(order_log.size()), 64'(2));
      if (order_log.size() == 2) begin
         check("t6_first_ch1", 64'(order_log[0]), 64'(2'b10));
         check("t6_then_ch0", 64'(order_log[1]), 64'(2'b01));
      end

      // Length saturation boundary, single requester back to back.
      add_pkt(1, 3, 16'hFFF8, 16'h1111, 16'h2222);
      add_pkt(1, 2, 16'hFFF7, 16'h3333, 16'h4444);
      run_until_done("t5_drain", 200);
      check("t5_len_err_total", 64'(lenerr_seen), 64'(1));

      // Both channels continuously requesting: strict rotation.
      order_log.delete();
      for (int p = 0; p < 2; p++) begin
         add_pkt(0, 5 + p, 16'(5 + p), 16'h5000, 16'h6000);
         add_pkt(1, 7 + p, 16'(7 + p), 16'h7000, 16'h8000);
      end
      run_until_done("t3_drain", 400);
      check("t3_order_n", 64'(order_log.size()), 64'(4));
      if (order_log.size() == 4) begin
         for (int i = 0; i < 4; i++)
            check("t3_order", 64'(order_log[i]), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
      end

      // Toggling downstream ready plus source bubbles, then random ready.
      bubbles_on = 1'b1;
      rdy_mode   = 1;
      for (int p = 0; p < 3; p++) begin
         add_pkt(1, $urandom_range(2, 16), 16'($urandom_range(1, 1500)), 16'($urandom), 16'($urandom));
      end
      add_pkt(0, $urandom_range(1, 16), 16'($urandom_range(1, 1500)), 16'($urandom), 16'($urandom));
      run_until_done("t4_toggle_drain", 2000);

      rdy_mode = 2;
      for (int p = 0; p < 6; p++) begin
         add_pkt(p % NUM_CH, $urandom_range(1, 16), 16'($urandom), 16'($urandom), 16'($urandom));
      end
      run_until_done("t4_random_drain", 4000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
